// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exc_pkg
//  Description : Shared types and constants for the MIPS exception controller:
//                FSM state encoding, architectural cause codes, default vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package exc_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } exc_state_e;

    // Architectural cause codes (ExcCode field values)
    localparam logic [4:0] CAUSE_OVF  = 5'd12;
    localparam logic [4:0] CAUSE_RI   = 5'd10;
    localparam logic [4:0] CAUSE_SYS  = 5'd8;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;

    // General exception handler entry point
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

endpackage : exc_pkg
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : exc_prio_enc
//  Description : Combinational lowest-index-first priority encoder. Index 0
//                is the oldest pipeline stage and therefore wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    assign valid = |req;

    // Scan from youngest to oldest so the lowest set index is written last
    always_comb begin
        index = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = i[IDX_W-1:0];
            end
        end
    end

endmodule : exc_prio_enc
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl
//  Description : Pipeline exception controller. Takes the oldest pending
//                request, latches EPC/Cause, pulses per-stage flushes and a
//                redirect to the handler vector, and returns to EPC on ERET.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          NUM_SRC = 4,
    parameter int          CAUSE_W = 5,
    parameter logic [31:0] VECTOR  = EXC_VECTOR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        exc_req,
    input  logic [NUM_SRC*CAUSE_W-1:0] exc_code,
    input  logic [NUM_SRC*32-1:0]     exc_pc,
    input  logic                      eret,
    output logic [NUM_SRC-1:0]        flush,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic [31:0]               epc,
    output logic [CAUSE_W-1:0]        cause,
    output logic                      exl,
    output logic [7:0]                missed_cnt
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    exc_state_e           state_q, state_d;
    logic [NUM_SRC-1:0]   flush_q, flush_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic [31:0]          epc_q, epc_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 exl_q, exl_d;
    logic [7:0]           missed_q, missed_d;

    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic [31:0]          win_pc;
    logic [CAUSE_W-1:0]   win_code;
    logic [NUM_SRC-1:0]   take_mask;

    exc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req     (exc_req),
        .valid   (win_valid),
        .index   (win_idx)
    );

    // Select the winner's PC/code and build the flush mask (winner and younger)
    always_comb begin
        win_pc    = '0;
        win_code  = '0;
        take_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i == int'(win_idx)) begin
                win_pc   = exc_pc[i*32 +: 32];
                win_code = exc_code[i*CAUSE_W +: CAUSE_W];
            end
            take_mask[i] = (i >= int'(win_idx));
        end
    end

    // Next-state and registered-output logic; pulses default low every cycle
    always_comb begin
        state_d          = state_q;
        flush_d          = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        exl_d            = exl_q;
        missed_d         = missed_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d          = ST_TAKE;
                    epc_d            = win_pc - 32'd4;
                    cause_d          = win_code;
                    flush_d          = take_mask;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = VECTOR;
                    exl_d            = 1'b1;
                end
            end
            ST_TAKE: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (eret) begin
                    state_d                = ST_RETURN;
                    redirect_valid_d       = 1'b1;
                    redirect_pc_d          = epc_q;
                    flush_d[NUM_SRC-1]     = 1'b1;
                    exl_d                  = 1'b0;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Requests seen while masked are counted, even on the ERET edge
        if ((state_q == ST_HANDLER) && (|exc_req) && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            flush_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            epc_q            <= '0;
            cause_q          <= '0;
            exl_q            <= 1'b0;
            missed_q         <= '0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            epc_q            <= epc_d;
            cause_q          <= cause_d;
            exl_q            <= exl_d;
            missed_q         <= missed_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign epc            = epc_q;
    assign cause          = cause_q;
    assign exl            = exl_q;
    assign missed_cnt     = missed_q;

endmodule : exc_ctrl
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_ctrl
//  Description : Directed self-checking bench for exc_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    localparam int NUM_SRC = 4;
    localparam int CAUSE_W = 5;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_SRC-1:0]          exc_req;
    logic [NUM_SRC*CAUSE_W-1:0]  exc_code;
    logic [NUM_SRC*32-1:0]       exc_pc;
    logic                        eret;
    logic [NUM_SRC-1:0]          flush;
    logic                        redirect_valid;
    logic [31:0]                 redirect_pc;
    logic [31:0]                 epc;
    logic [CAUSE_W-1:0]          cause;
    logic                        exl;
    logic [7:0]                  missed_cnt;

    int n_pass;
    int n_total;

    exc_ctrl #(
        .NUM_SRC (NUM_SRC),
        .CAUSE_W (CAUSE_W),
        .VECTOR  (32'h8000_0180)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .eret           (eret),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .cause          (cause),
        .exl            (exl),
        .missed_cnt     (missed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] pc, input logic [4:0] code);
        exc_pc[i*32 +: 32]           = pc;
        exc_code[i*CAUSE_W +: CAUSE_W] = code;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        exc_req  = '0;
        exc_code = '0;
        exc_pc   = '0;
        eret     = 1'b0;

        // Reset state
        #12;
        chk("rst_flush",   32'(flush), 32'h0);
        chk("rst_rv",      32'(redirect_valid), 32'h0);
        chk("rst_rpc",     redirect_pc, 32'h0);
        chk("rst_epc",     epc, 32'h0);
        chk("rst_cause",   32'(cause), 32'h0);
        chk("rst_exl",     32'(exl), 32'h0);
        chk("rst_missed",  32'(missed_cnt), 32'h0);
        rst_n = 1'b1;
        step();

        // ERET in IDLE is ignored
        eret = 1'b1;
        step();
        chk("idle_eret_rv",    32'(redirect_valid), 32'h0);
        chk("idle_eret_flush", 32'(flush), 32'h0);
        eret = 1'b0;

        // Single request from stage 2
        set_src(2, 32'h0040_0010, 5'd12);
        exc_req = 4'b0100;
        step();
        chk("s_flush", 32'(flush), 32'hC);
        chk("s_rv",    32'(redirect_valid), 32'h1);
        chk("s_rpc",   redirect_pc, 32'h8000_0180);
        chk("s_epc",   epc, 32'h0040_000C);
        chk("s_cause", 32'(cause), 32'd12);
        chk("s_exl",   32'(exl), 32'h1);
        exc_req = 4'b0000;
        step();
        chk("h_rv",     32'(redirect_valid), 32'h0);
        chk("h_flush",  32'(flush), 32'h0);
        chk("h_exl",    32'(exl), 32'h1);
        chk("h_missed", 32'(missed_cnt), 32'h0);

        // Masked requests in HANDLER saturate the miss counter
        set_src(0, 32'h1234_5678, 5'd4);
        exc_req = 4'b0001;
        step();
        chk("m_missed1", 32'(missed_cnt), 32'h1);
        chk("m_rv1",     32'(redirect_valid), 32'h0);
        for (int i = 0; i < 299; i++) step();
        chk("m_missed_sat", 32'(missed_cnt), 32'hFF);
        chk("m_epc",        epc, 32'h0040_000C);
        chk("m_cause",      32'(cause), 32'd12);
        chk("m_exl",        32'(exl), 32'h1);

        // Return from handler
        exc_req = 4'b0000;
        eret    = 1'b1;
        step();
        chk("r_rv",    32'(redirect_valid), 32'h1);
        chk("r_rpc",   redirect_pc, 32'h0040_000C);
        chk("r_flush", 32'(flush), 32'h8);
        chk("r_exl",   32'(exl), 32'h0);
        eret = 1'b0;
        step();
        chk("i_rv",    32'(redirect_valid), 32'h0);
        chk("i_flush", 32'(flush), 32'h0);
        chk("i_exl",   32'(exl), 32'h0);

        // Priority between stages 1 and 3
        set_src(1, 32'h0040_0100, 5'd10);
        set_src(3, 32'h0040_0200, 5'd12);
        exc_req = 4'b1010;
        step();
        chk("p_cause", 32'(cause), 32'd10);
        chk("p_flush", 32'(flush), 32'hE);
        chk("p_epc",   epc, 32'h0040_00FC);
        chk("p_rv",    32'(redirect_valid), 32'h1);
        exc_req = 4'b0000;
        step();
        // ERET and request on the same edge: ERET wins
        eret    = 1'b1;
        exc_req = 4'b0001;
        step();
        chk("pe_rv",    32'(redirect_valid), 32'h1);
        chk("pe_rpc",   redirect_pc, 32'h0040_00FC);
        chk("pe_cause", 32'(cause), 32'd10);
        eret    = 1'b0;
        exc_req = 4'b0000;
        step();

        // Wrap-around EPC, and ERET during TAKE is ignored
        set_src(0, 32'h0000_0000, 5'd4);
        exc_req = 4'b0001;
        step();
        chk("w_epc",   epc, 32'hFFFF_FFFC);
        chk("w_flush", 32'(flush), 32'hF);
        chk("w_cause", 32'(cause), 32'd4);
        exc_req = 4'b0000;
        eret    = 1'b1;
        step();
        chk("t_eret_rv",  32'(redirect_valid), 32'h0);
        chk("t_eret_exl", 32'(exl), 32'h1);
        eret = 1'b0;
        step();
        chk("t_hold_rv",  32'(redirect_valid), 32'h0);
        chk("t_hold_exl", 32'(exl), 32'h1);

        // Asynchronous reset in HANDLER
        rst_n = 1'b0;
        #2;
        chk("ar_exl",    32'(exl), 32'h0);
        chk("ar_epc",    epc, 32'h0);
        chk("ar_cause",  32'(cause), 32'h0);
        chk("ar_rpc",    redirect_pc, 32'h0);
        chk("ar_missed", 32'(missed_cnt), 32'h0);
        #3;
        rst_n = 1'b1;

        // Next request taken normally
        set_src(2, 32'h0040_0010, 5'd12);
        exc_req = 4'b0100;
        step();
        chk("n_flush", 32'(flush), 32'hC);
        chk("n_rv",    32'(redirect_valid), 32'h1);
        chk("n_epc",   epc, 32'h0040_000C);
        chk("n_exl",   32'(exl), 32'h1);
        exc_req = 4'b0000;
        step();
        chk("n_rv_end", 32'(redirect_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_exc_ctrl
`default_nettype wire

// File: doc/exc_ctrl.md
# exc_ctrl

Parametrised, clocked exception controller for the 32-bit MIPS pipeline. It arbitrates one exception request per pipeline stage, oldest stage first, and latches EPC and a multi-bit Cause code. It then issues per-stage flushes and a PC redirect to the handler vector, and later redirects back to EPC on ERET. It sits beside the hazard unit and drives the flush inputs of the inter-stage registers and the PC-select mux.

## Interface
Parameters:
- NUM_SRC, 4: number of exception-reporting stages. Index 0 is the oldest stage (MEM) and has the highest priority.
- CAUSE_W, 5: width of each cause code.
- VECTOR, 32'h8000_0180: handler entry address.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exc_req  in  NUM_SRC  per-stage exception request, level, sampled each edge.
- exc_code  in  NUM_SRC*CAUSE_W  cause code of stage i in slice [i*CAUSE_W +: CAUSE_W].
- exc_pc  in  NUM_SRC*32  PC+4 of the instruction in stage i, in slice [i*32 +: 32].
- eret  in  1  ERET decoded in ID, level, sampled each edge.
- flush  out  NUM_SRC  flush for stage i's input register, one-cycle pulse.
- redirect_valid  out  1  PC mux must load redirect_pc, one-cycle pulse.
- redirect_pc  out  32  target PC.
- epc  out  32  latched exception PC.
- cause  out  CAUSE_W  latched cause code.
- exl  out  1  high while in handler; exceptions are masked.
- missed_cnt  out  8  saturating count of requests arriving while exl=1.

## Operation
- FSM states: IDLE, TAKE, HANDLER, RETURN.
- IDLE with any exc_req bit set goes to TAKE. Winner w is the lowest set index.
  - Latch epc = exc_pc[w] − 4, modulo 2^32.
  - Latch cause = exc_code[w].
  - Register flush[j]=1 for all j ≥ w, 0 for j < w, so older stages drain.
  - Register redirect_pc = VECTOR.
- TAKE lasts one cycle, with flush and redirect_valid asserted, then goes to HANDLER. exl=1 from TAKE onward.
- HANDLER ignores exc_req. Each edge with any exc_req bit set increments missed_cnt, saturating at 8'hFF. epc and cause are not overwritten.
- HANDLER with eret=1 goes to RETURN. Register redirect_pc = epc and flush = {NUM_SRC{1'b0}} except the youngest bit (IF/ID), which is 1.
- RETURN lasts one cycle, with redirect_valid asserted, then goes to IDLE. exl=0 in RETURN.
- eret in IDLE or TAKE is ignored: no redirect, no state change.
- Same edge in HANDLER with eret and exc_req: eret wins, and the request still counts toward missed_cnt.
- missed_cnt clears only on reset.

## Timing
- Reset values:
  - All outputs 0: flush=0, redirect_valid=0, redirect_pc=0, epc=0, cause=0, exl=0, missed_cnt=0.
  - State IDLE.
- Reset is asynchronous. Asserting it mid-TAKE or mid-HANDLER clears everything immediately, and no pulse completes.
- All outputs are registered. A request sampled at edge k gives flush, redirect_valid and redirect_pc during cycle k+1, exactly one cycle wide.
- epc, cause and exl are valid from cycle k+1.
- Minimum exception-to-return cost is 3 edges: TAKE, HANDLER with eret, RETURN.
- Back-to-back exceptions in IDLE are impossible, since TAKE always precedes a masked HANDLER.
- No back-pressure: consumers must act on the pulse in the cycle it is high.

## Structure
- Package exc_pkg holds:
  - FSM state enum.
  - Cause code constants: CAUSE_OVF=5'd12, CAUSE_RI=5'd10, CAUSE_SYS=5'd8, CAUSE_ADEL=5'd4.
  - Default VECTOR.
- One sub-module, exc_prio_enc: NUM_SRC-wide lowest-index-first priority encoder with outputs valid and index[$clog2(NUM_SRC)-1:0]. It is purely combinational.

## Test plan
- Single request: exc_req=4'b0100, exc_pc[2]=32'h0040_0010, exc_code[2]=12 → next cycle flush=4'b1100, redirect_valid=1, redirect_pc=32'h8000_0180; then epc=32'h0040_000C, cause=12, exl=1.
- Priority: exc_req=4'b1010 with codes 10 (index 1) and 12 (index 3) → cause=10, flush=4'b1110, epc from exc_pc[1].
- Masking and saturation: in HANDLER, hold exc_req≠0 for 300 cycles → epc and cause unchanged, missed_cnt=8'hFF.
- Return: eret in HANDLER with epc=32'h0040_000C → next cycle redirect_valid=1, redirect_pc=32'h0040_000C, flush=4'b1000, then IDLE with exl=0. A separate run with eret in IDLE gives no pulse.
- Wrap-around: exc_pc=32'h0000_0000 → epc=32'hFFFF_FFFC.
- Reset mid-handler: rst_n low for half a cycle during HANDLER → all outputs 0 asynchronously. The next request is taken normally.
